frame_queue: RTL and testbench

Frame-aware successor to the single-word Ethernet queue. It stores words with an end-of-frame marker and exposes only fully committed frames to the reader. A frame in progress can be aborted by the writer, and a frame that overflows storage is discarded automatically. It sits between the MAC receive path and the protocol parsers, so a bad-CRC or oversize frame never reaches downstream logic.

---
 rtl/frame_queue_pkg.sv | 14 +
 rtl/frame_queue_ram.sv | 27 ++
 rtl/frame_queue.sv | 141 ++++++++++++++
 tb/tb_frame_queue.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_queue_pkg.sv
// Shared definitions for the frame-aware receive queue: write FSM encoding
// and the pointer-width helper.
package frame_queue_pkg;

    typedef enum logic {
        ST_ACCEPT  = 1'b0,
        ST_DISCARD = 1'b1
    } wr_state_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/frame_queue_ram.sv
// Frame queue storage: one synchronous write port, one asynchronous read port.
module frame_queue_ram #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; validity is tracked entirely by the pointers,
    // and leaving it out lets the array map onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/frame_queue.sv
// Frame-aware FIFO: words become visible to the reader only once their frame
// is committed by wr_last; aborted or overflowing frames are rolled back.
module frame_queue
    import frame_queue_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int DEPTH             = 16,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_last,
    input  logic                  wr_drop,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_last,
    output logic                  empty,
    output logic [$clog2(DEPTH):0] rd_level,
    output logic [$clog2(DEPTH):0] frame_count
);

    localparam int PTR_WIDTH = ptr_width(DEPTH);
    typedef logic [PTR_WIDTH:0] ptr_t;
    localparam ptr_t DEPTH_P  = ptr_t'(DEPTH);
    localparam ptr_t AF_LEVEL = ptr_t'(ALMOST_FULL_LEVEL);
    localparam ptr_t ONE      = ptr_t'(1);

    wr_state_t state, state_nxt;
    ptr_t      wp, cp, rp;
    ptr_t      wp_nxt, cp_nxt, rp_nxt;
    ptr_t      frame_count_nxt;
    ptr_t      used;
    logic      overflow_nxt;
    logic      mem_we;
    logic      commit;
    logic      pop_last;
    logic [DATA_WIDTH:0] rd_word;

    frame_queue_ram #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH),
        .AW    (PTR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wp[PTR_WIDTH-1:0]),
        .wdata ({wr_last, din}),
        .raddr (rp[PTR_WIDTH-1:0]),
        .rdata (rd_word)
    );

    assign used        = wp - rp;
    assign rd_level    = cp - rp;
    assign empty       = (cp == rp);
    assign full        = (used == DEPTH_P);
    assign almost_full = (used >= AF_LEVEL);
    assign dout        = empty ? '0 : rd_word[DATA_WIDTH-1:0];
    assign dout_last   = empty ? 1'b0 : rd_word[DATA_WIDTH];

    // NOTE: every signal gets a default before any branch so no path leaves
    // a value held, which would otherwise infer a latch.
    always_comb begin
        state_nxt    = state;
        wp_nxt       = wp;
        cp_nxt       = cp;
        rp_nxt       = rp;
        overflow_nxt = 1'b0;
        mem_we       = 1'b0;
        commit       = 1'b0;
        pop_last     = 1'b0;

        if (rd_en && !empty) begin
            rp_nxt   = rp + ONE;
            pop_last = rd_word[DATA_WIDTH];
        end

        if (wr_drop) begin
            wp_nxt    = cp;
            state_nxt = ST_ACCEPT;
        end else if (wr_en) begin
            unique case (state)
                ST_ACCEPT: begin
                    if (!full) begin
                        mem_we = 1'b1;
                        wp_nxt = wp + ONE;
                        if (wr_last) begin
                            cp_nxt = wp + ONE;
                            commit = 1'b1;
                        end
                    end else if (wr_last) begin
                        // Frame ends on the very word that found storage full.
                        wp_nxt       = cp;
                        overflow_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (wr_last) begin
                        wp_nxt       = cp;
                        overflow_nxt = 1'b1;
                        state_nxt    = ST_ACCEPT;
                    end
                end
                default: state_nxt = ST_ACCEPT;
            endcase
        end

        unique case ({commit, pop_last})
            2'b10:   frame_count_nxt = frame_count + ONE;
            2'b01:   frame_count_nxt = frame_count - ONE;
            default: frame_count_nxt = frame_count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ACCEPT;
            wp          <= '0;
            cp          <= '0;
            rp          <= '0;
            frame_count <= '0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_nxt;
            wp          <= wp_nxt;
            cp          <= cp_nxt;
            rp          <= rp_nxt;
            frame_count <= frame_count_nxt;
            overflow    <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_frame_queue.sv
// Self-checking bench for frame_queue: directed scenarios plus random traffic,
// all compared against a queue-based frame model.
module tb_frame_queue;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AFL   = DEPTH - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en, wr_last, wr_drop, rd_en;
    logic [DW-1:0] din;
    logic          full, almost_full, overflow, dout_last, empty;
    logic [DW-1:0] dout;
    logic [3:0]    rd_level, frame_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: committed words readable now, pending words of the open frame.
    logic [DW:0] committed[$];
    logic [DW:0] pending[$];
    bit          discarding;
    bit          ovf_exp;

    frame_queue #(
        .DATA_WIDTH        (DW),
        .DEPTH             (DEPTH),
        .ALMOST_FULL_LEVEL (AFL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .din         (din),
        .wr_last     (wr_last),
        .wr_drop     (wr_drop),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .rd_en       (rd_en),
        .dout        (dout),
        .dout_last   (dout_last),
        .empty       (empty),
        .rd_level    (rd_level),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        committed.delete();
        pending.delete();
        discarding = 1'b0;
        ovf_exp    = 1'b0;
    endtask

    task automatic model_update(input bit we, input logic [DW-1:0] d, input bit last,
                                input bit drop, input bit re);
        bit is_full;
        is_full = (committed.size() + pending.size()) == DEPTH;
        ovf_exp = 1'b0;
        if (re && committed.size() > 0) void'(committed.pop_front());
        if (drop) begin
            pending.delete();
            discarding = 1'b0;
        end else if (we) begin
            if (discarding) begin
                if (last) begin
                    pending.delete();
                    discarding = 1'b0;
                    ovf_exp    = 1'b1;
                end
            end else if (!is_full) begin
                pending.push_back({last, d});
                if (last) begin
                    foreach (pending[i]) committed.push_back(pending[i]);
                    pending.delete();
                end
            end else if (last) begin
                pending.delete();
                ovf_exp = 1'b1;
            end else begin
                discarding = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        int used;
        int frames;
        used   = committed.size() + pending.size();
        frames = 0;
        foreach (committed[i]) if (committed[i][DW]) frames++;
        check("empty", empty, committed.size() == 0);
        check("full", full, used == DEPTH);
        check("almost_full", almost_full, used >= AFL);
        check("overflow", overflow, ovf_exp);
        check("rd_level", rd_level, committed.size());
        check("frame_count", frame_count, frames);
        check("dout", dout, committed.size() > 0 ? committed[0][DW-1:0] : '0);
        check("dout_last", dout_last, committed.size() > 0 ? committed[0][DW] : 1'b0);
    endtask

    task automatic step(input bit we, input logic [DW-1:0] d, input bit last,
                        input bit drop, input bit re);
        wr_en   = we;
        din     = d;
        wr_last = last;
        wr_drop = drop;
        rd_en   = re;
        @(posedge clk);
        model_update(we, d, last, drop, re);
        #1;
        compare_all();
    endtask

    task automatic wr(input logic [DW-1:0] d, input bit last);
        step(1'b1, d, last, 1'b0, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_empty"}, empty, 1'b1);
        check({tag, "_full"}, full, 1'b0);
        check({tag, "_almost_full"}, almost_full, 1'b0);
        check({tag, "_overflow"}, overflow, 1'b0);
        check({tag, "_dout"}, dout, 8'h00);
        check({tag, "_dout_last"}, dout_last, 1'b0);
        check({tag, "_rd_level"}, rd_level, 4'd0);
        check({tag, "_frame_count"}, frame_count, 4'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        din     = '0;
        wr_last = 1'b0;
        wr_drop = 1'b0;
        rd_en   = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("por");
        #16;
        rst_n = 1'b1;
        idle();

        // Three-word frame becomes visible only after its last word.
        wr(8'h11, 1'b0);
        check("s1_empty_w1", empty, 1'b1);
        wr(8'h22, 1'b0);
        wr(8'h33, 1'b1);
        check("s1_dout", dout, 8'h11);
        check("s1_rd_level", rd_level, 4'd3);
        check("s1_frames", frame_count, 4'd1);
        rd();
        rd();
        check("s1_last", dout_last, 1'b1);
        rd();
        check("s1_empty_end", empty, 1'b1);

        // Abort with the final word.
        wr(8'h01, 1'b0);
        wr(8'h02, 1'b0);
        step(1'b1, 8'h03, 1'b1, 1'b1, 1'b0);
        check("s2_empty", empty, 1'b1);
        check("s2_ovf", overflow, 1'b0);

        // Ten-word frame into an eight-word queue.
        for (int i = 0; i < 10; i++) wr(8'h40 + 8'(i), i == 9);
        check("s3_ovf_pulse", overflow, 1'b1);
        idle();
        check("s3_ovf_gone", overflow, 1'b0);

        // Committed frame A survives B's overflow.
        for (int i = 0; i < 5; i++) wr(8'hA0 + 8'(i), i == 4);
        for (int i = 0; i < 5; i++) wr(8'hB0 + 8'(i), i == 4);
        check("s4_ovf", overflow, 1'b1);
        for (int i = 0; i < 5; i++) rd();
        check("s4_frames", frame_count, 4'd0);

        // Commit and last-word pop in the same cycle.
        wr(8'hC1, 1'b1);
        step(1'b1, 8'hC2, 1'b1, 1'b0, 1'b1);
        check("s5_frames", frame_count, 4'd1);
        check("s5_level", rd_level, 4'd1);
        rd();

        // Asynchronous reset with committed and in-flight words.
        for (int i = 0; i < 4; i++) wr(8'hD0 + 8'(i), i == 3);
        wr(8'hE0, 1'b0);
        wr(8'hE1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_last = 1'b0;
        #10;
        rst_n = 1'b1;
        model_reset();
        idle();

        // Random traffic with alternating light and heavy read phases.
        for (int i = 0; i < 3000; i++) begin
            int rd_pct;
            rd_pct = ((i / 200) % 2) ? 80 : 15;
            step($urandom_range(0, 99) < 65, 8'($urandom), $urandom_range(0, 99) < 18,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < rd_pct);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
